// File: rtl/alu_cmd_sequencer.sv
// Command front-end and register file wrapped around an external combinational ALU.
// Accepts one command per handshake, runs it through the ALU and returns the result.
module alu_cmd_sequencer #(
   parameter int WIDTH  = 8,
   parameter int REG_AW = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid_i,
   output logic              cmd_ready_o,
   input  logic              cmd_load_i,
   input  logic [2:0]        cmd_op_i,
   input  logic [REG_AW-1:0] cmd_rd_i,
   input  logic [REG_AW-1:0] cmd_ra_i,
   input  logic [REG_AW-1:0] cmd_rb_i,
   input  logic [WIDTH-1:0]  cmd_imm_i,
   output logic [WIDTH-1:0]  alu_a_o,
   output logic [WIDTH-1:0]  alu_b_o,
   output logic [2:0]        alu_sel_o,
   input  logic [WIDTH-1:0]  alu_result_i,
   output logic              res_valid_o,
   input  logic              res_ready_i,
   output logic [WIDTH-1:0]  res_data_o,
   output logic              res_zero_o,
   output logic              res_neg_o,
   output logic              busy_o
);

   localparam int NREG = 1 << REG_AW;

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t              state_q, state_d;
   logic [WIDTH-1:0]    rf_q [NREG];
   logic [WIDTH-1:0]    rf_d [NREG];
   logic [WIDTH-1:0]    alu_a_q, alu_a_d;
   logic [WIDTH-1:0]    alu_b_q, alu_b_d;
   logic [2:0]          alu_sel_q, alu_sel_d;
   logic [REG_AW-1:0]   rd_q, rd_d;
   logic                load_q, load_d;
   logic [WIDTH-1:0]    imm_q, imm_d;
   logic [WIDTH-1:0]    res_data_q, res_data_d;
   logic                res_zero_q, res_zero_d;
   logic                res_neg_q, res_neg_d;
   logic                res_valid_q, res_valid_d;
   logic [WIDTH-1:0]    wdata;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         alu_sel_q   <= '0;
         rd_q        <= '0;
         load_q      <= 1'b0;
         imm_q       <= '0;
         res_data_q  <= '0;
         res_zero_q  <= 1'b0;
         res_neg_q   <= 1'b0;
         res_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         rf_q        <= rf_d;
         alu_a_q     <= alu_a_d;
         alu_b_q     <= alu_b_d;
         alu_sel_q   <= alu_sel_d;
         rd_q        <= rd_d;
         load_q      <= load_d;
         imm_q       <= imm_d;
         res_data_q  <= res_data_d;
         res_zero_q  <= res_zero_d;
         res_neg_q   <= res_neg_d;
         res_valid_q <= res_valid_d;
      end
   end

   // Operands are sampled at accept, so a command whose rd matches ra/rb sees the old value.
   always_comb begin
      state_d     = state_q;
      rf_d        = rf_q;
      alu_a_d     = alu_a_q;
      alu_b_d     = alu_b_q;
      alu_sel_d   = alu_sel_q;
      rd_d        = rd_q;
      load_d      = load_q;
      imm_d       = imm_q;
      res_data_d  = res_data_q;
      res_zero_d  = res_zero_q;
      res_neg_d   = res_neg_q;
      res_valid_d = res_valid_q;
      wdata       = load_q ? imm_q : alu_result_i;
      case (state_q)
         IDLE: begin
            if (cmd_valid_i) begin
               alu_a_d   = rf_q[cmd_ra_i];
               alu_b_d   = rf_q[cmd_rb_i];
               alu_sel_d = cmd_op_i;
               rd_d      = cmd_rd_i;
               load_d    = cmd_load_i;
               imm_d     = cmd_imm_i;
               state_d   = EXEC;
            end
         end
         EXEC: begin
            rf_d[rd_q]  = wdata;
            res_data_d  = wdata;
            res_zero_d  = (wdata == '0);
            res_neg_d   = wdata[WIDTH-1];
            res_valid_d = 1'b1;
            state_d     = RESP;
         end
         RESP: begin
            if (res_ready_i) begin
               res_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign cmd_ready_o = (state_q == IDLE);
   assign busy_o      = (state_q != IDLE);
   assign alu_a_o     = alu_a_q;
   assign alu_b_o     = alu_b_q;
   assign alu_sel_o   = alu_sel_q;
   assign res_valid_o = res_valid_q;
   assign res_data_o  = res_data_q;
   assign res_zero_o  = res_zero_q;
   assign res_neg_o   = res_neg_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer: behavioural ALU, register-file model,
// directed scenarios followed by randomized commands with random backpressure.
module tb_alu_cmd_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       cmdValid, cmdReady, cmdLoad;
   logic [2:0] cmdOp;
   logic [1:0] cmdRd, cmdRa, cmdRb;
   logic [7:0] cmdImm;
   logic [7:0] aluA, aluB, aluResult;
   logic [2:0] aluSel;
   logic       resValid, resReady, resZero, resNeg, busy;
   logic [7:0] resData;

   int         checkCount = 0;
   int         failCount  = 0;
   logic [7:0] refRf [4];
   logic [7:0] lastData;

   alu_cmd_sequencer #(.WIDTH(8), .REG_AW(2)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid_i(cmdValid), .cmd_ready_o(cmdReady), .cmd_load_i(cmdLoad),
      .cmd_op_i(cmdOp), .cmd_rd_i(cmdRd), .cmd_ra_i(cmdRa), .cmd_rb_i(cmdRb),
      .cmd_imm_i(cmdImm),
      .alu_a_o(aluA), .alu_b_o(aluB), .alu_sel_o(aluSel), .alu_result_i(aluResult),
      .res_valid_o(resValid), .res_ready_i(resReady), .res_data_o(resData),
      .res_zero_o(resZero), .res_neg_o(resNeg), .busy_o(busy)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] aluFn(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      int r;
      case (op)
         3'd0:    r = (int'(a) + int'(b)) % 256;
         3'd1:    r = (int'(a) - int'(b) + 256) % 256;
         3'd2:    r = int'(a & b);
         3'd3:    r = int'(a | b);
         3'd4:    r = 255 - int'(a);
         default: r = 0;
      endcase
      return r[7:0];
   endfunction

   assign aluResult = aluFn(aluSel, aluA, aluB);

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checkCount++;
      assert (obs === exp) else begin
         failCount++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Issues one command from a negedge, checks accept/EXEC/RESP, holds the response for
   // holdCycles with a competing cmd_valid, then completes the handshake. Ends at a negedge.
   task automatic applyStimulus(input logic load, input logic [2:0] op, input logic [1:0] rd,
                                input logic [1:0] ra, input logic [1:0] rb, input logic [7:0] imm,
                                input int holdCycles);
      logic [7:0] expA, expB, expData;
      expA    = refRf[ra];
      expB    = refRf[rb];
      expData = load ? imm : aluFn(op, expA, expB);
      checkOutput("idle_cmd_ready", 32'(cmdReady), 32'd1);
      cmdValid = 1'b1; cmdLoad = load; cmdOp = op; cmdRd = rd; cmdRa = ra; cmdRb = rb; cmdImm = imm;
      @(posedge clk);
      @(negedge clk);
      cmdValid = 1'b0;
      cmdOp = 3'($urandom_range(0, 7)); cmdRa = 2'($urandom_range(0, 3));
      checkOutput("exec_busy", 32'(busy), 32'd1);
      checkOutput("exec_cmd_ready", 32'(cmdReady), 32'd0);
      checkOutput("exec_res_valid", 32'(resValid), 32'd0);
      checkOutput("exec_alu_a", 32'(aluA), 32'(expA));
      checkOutput("exec_alu_b", 32'(aluB), 32'(expB));
      checkOutput("exec_alu_sel", 32'(aluSel), 32'(op));
      @(posedge clk);
      @(negedge clk);
      refRf[rd] = expData;
      lastData  = resData;
      checkOutput("resp_valid", 32'(resValid), 32'd1);
      checkOutput("resp_data", 32'(resData), 32'(expData));
      checkOutput("resp_zero", 32'(resZero), 32'(expData == 8'd0));
      checkOutput("resp_neg", 32'(resNeg), 32'(expData[7]));
      for (int i = 0; i < holdCycles; i++) begin
         resReady = 1'b0;
         cmdValid = 1'b1; cmdLoad = 1'b1; cmdRd = rd; cmdImm = ~expData;
         @(posedge clk);
         @(negedge clk);
         checkOutput("hold_valid", 32'(resValid), 32'd1);
         checkOutput("hold_data", 32'(resData), 32'(expData));
         checkOutput("hold_flags", {30'd0, resZero, resNeg}, {30'd0, expData == 8'd0, expData[7]});
         checkOutput("hold_cmd_ready", 32'(cmdReady), 32'd0);
      end
      cmdValid = 1'b0;
      resReady = 1'b1;
      @(posedge clk);
      @(negedge clk);
      resReady = 1'b0;
      checkOutput("done_res_valid", 32'(resValid), 32'd0);
      checkOutput("done_cmd_ready", 32'(cmdReady), 32'd1);
      checkOutput("done_busy", 32'(busy), 32'd0);
   endtask

   initial begin
      rst = 1'b1; cmdValid = 1'b0; cmdLoad = 1'b0; cmdOp = '0; cmdRd = '0; cmdRa = '0;
      cmdRb = '0; cmdImm = '0; resReady = 1'b0; lastData = '0;
      for (int i = 0; i < 4; i++) refRf[i] = 8'd0;
      #1;
      checkOutput("rst_state", {23'd0, resValid, busy, resZero, resNeg, aluSel},
                  {23'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0});
      checkOutput("rst_alu_ab", {16'd0, aluA, aluB}, 32'd0);
      checkOutput("rst_res_data", 32'(resData), 32'd0);
      checkOutput("rst_cmd_ready", 32'(cmdReady), 32'd1);
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      $display("[TB] basic ops");
      applyStimulus(1'b1, 3'd0, 2'd0, 2'd0, 2'd0, 8'h05, 0);
      applyStimulus(1'b1, 3'd0, 2'd1, 2'd0, 2'd0, 8'h03, 0);
      applyStimulus(1'b0, 3'd0, 2'd2, 2'd0, 2'd1, 8'h00, 0);
      checkOutput("add_const", 32'(lastData), 32'h08);
      applyStimulus(1'b0, 3'd3, 2'd2, 2'd2, 2'd2, 8'h00, 0);
      checkOutput("r2_readback", 32'(lastData), 32'h08);
      applyStimulus(1'b0, 3'd1, 2'd3, 2'd1, 2'd0, 8'h00, 0);
      checkOutput("sub_const", 32'(lastData), 32'hFE);
      applyStimulus(1'b1, 3'd0, 2'd0, 2'd0, 2'd0, 8'hF0, 0);
      applyStimulus(1'b1, 3'd0, 2'd1, 2'd0, 2'd0, 8'h3C, 0);
      applyStimulus(1'b0, 3'd2, 2'd2, 2'd0, 2'd1, 8'h00, 0);
      checkOutput("and_const", 32'(lastData), 32'h30);
      applyStimulus(1'b1, 3'd0, 2'd1, 2'd0, 2'd0, 8'h0F, 0);
      applyStimulus(1'b0, 3'd3, 2'd2, 2'd0, 2'd1, 8'h00, 0);
      checkOutput("or_const", 32'(lastData), 32'hFF);
      applyStimulus(1'b0, 3'd4, 2'd3, 2'd2, 2'd0, 8'h00, 0);
      checkOutput("not_const", 32'(lastData), 32'h00);

      $display("[TB] wrap and accumulate");
      applyStimulus(1'b1, 3'd0, 2'd0, 2'd0, 2'd0, 8'hFF, 0);
      applyStimulus(1'b1, 3'd0, 2'd1, 2'd0, 2'd0, 8'h01, 0);
      applyStimulus(1'b0, 3'd0, 2'd2, 2'd0, 2'd1, 8'h00, 0);
      checkOutput("wrap_const", 32'(lastData), 32'h00);
      applyStimulus(1'b1, 3'd0, 2'd0, 2'd0, 2'd0, 8'h00, 0);
      applyStimulus(1'b1, 3'd0, 2'd1, 2'd0, 2'd0, 8'h03, 0);
      for (int k = 1; k <= 3; k++) begin
         applyStimulus(1'b0, 3'd0, 2'd0, 2'd0, 2'd1, 8'h00, 0);
         checkOutput("accum_const", 32'(lastData), 32'(3 * k));
      end

      $display("[TB] backpressure and reserved op");
      applyStimulus(1'b0, 3'd0, 2'd3, 2'd0, 2'd1, 8'h00, 5);
      applyStimulus(1'b1, 3'd0, 2'd0, 2'd0, 2'd0, 8'h05, 0);
      applyStimulus(1'b0, 3'd6, 2'd1, 2'd0, 2'd0, 8'h00, 0);
      checkOutput("reserved_const", 32'(lastData), 32'h00);

      $display("[TB] random commands");
      for (int n = 0; n < 60; n++) begin
         applyStimulus(1'($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)),
                       2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                       2'($urandom_range(0, 3)), 8'($urandom), $urandom_range(0, 2));
      end

      $display("[TB] reset during EXEC");
      applyStimulus(1'b1, 3'd0, 2'd2, 2'd0, 2'd0, 8'hA5, 0);
      cmdValid = 1'b1; cmdLoad = 1'b0; cmdOp = 3'd3; cmdRd = 2'd3; cmdRa = 2'd2; cmdRb = 2'd2;
      @(posedge clk);
      @(negedge clk);
      cmdValid = 1'b0;
      checkOutput("pre_rst_busy", 32'(busy), 32'd1);
      rst = 1'b1;
      #1;
      checkOutput("mid_rst_res_valid", 32'(resValid), 32'd0);
      checkOutput("mid_rst_busy", 32'(busy), 32'd0);
      checkOutput("mid_rst_alu", {13'd0, aluA, aluB, aluSel}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) refRf[i] = 8'd0;
      @(negedge clk);
      checkOutput("post_rst_cmd_ready", 32'(cmdReady), 32'd1);
      checkOutput("post_rst_res_valid", 32'(resValid), 32'd0);
      for (int r = 0; r < 4; r++) begin
         applyStimulus(1'b0, 3'd3, 2'(r), 2'(r), 2'(r), 8'h00, 0);
         checkOutput("post_rst_reg_zero", 32'(lastData), 32'h00);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule
